// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-requester memory arbiter: state encoding,
// default widths and requester indices.
package mem_arb_pkg;

    localparam int AW_DEFAULT        = 12;
    localparam int DW_DEFAULT        = 32;
    localparam int MAX_BURST_DEFAULT = 8;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pointer and the IDLE-state owner selection.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic release_own,
    input  logic release_id,
    output logic pick,
    output logic any_req
);

    logic ptr;

    // Whoever just gave up ownership loses the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= REQ_CORE;
        end else if (release_own) begin
            ptr <= ~release_id;
        end
    end

    assign any_req = req0 | req1;
    assign pick    = (req0 & req1) ? ptr : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between the core (m0) and a loader/debug
// port (m1), with bursts capped at MAX_BURST while the other side waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = AW_DEFAULT,
    parameter int DW        = DW_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] burst_cnt, cnt_nxt;
    logic          own0, own1, xfer, exit_own, pick, any_req;
    logic          cur_req, cur_we, cur_lock, other_req;

    // Handshake: a requester holds req (with we/addr/wdata stable) until it
    // sees gnt; a cycle with req & gnt is one transfer, committed at the edge.
    assign own0   = (state == ST_OWN0);
    assign own1   = (state == ST_OWN1);
    assign m0_gnt = own0 & m0_req;
    assign m1_gnt = own1 & m1_req;
    assign xfer   = m0_gnt | m1_gnt;

    assign cur_req   = own1 ? m1_req  : m0_req;
    assign cur_we    = own1 ? m1_we   : m0_we;
    assign cur_lock  = own1 ? m1_lock : m0_lock;
    assign other_req = own1 ? m0_req  : m1_req;

    always_comb begin
        cnt_nxt = burst_cnt;
        if (xfer && (burst_cnt != CW'(MAX_BURST))) begin
            cnt_nxt = burst_cnt + 1'b1;
        end
    end

    // The cap counts this cycle's transfer, so the owner gets exactly MAX_BURST.
    assign exit_own = (own0 | own1) &
                      ((~cur_req & ~cur_lock) | ((cnt_nxt == CW'(MAX_BURST)) & other_req));

    rr_arb2 u_rr (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0        (m0_req),
        .req1        (m1_req),
        .release_own (exit_own),
        .release_id  (own1),
        .pick        (pick),
        .any_req     (any_req)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = pick ? ST_OWN1 : ST_OWN0;
            ST_OWN0,
            ST_OWN1: if (exit_own) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= (state_nxt != state) ? '0 : cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt & ~m0_we) m0_rdata <= mem_rd;
            if (m1_gnt & ~m1_we) m1_rdata <= mem_rd;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_wd   = '0;
        if (own0) begin
            mem_addr = m0_addr;
            mem_wd   = m0_wdata;
        end else if (own1) begin
            mem_addr = m1_addr;
            mem_wd   = m1_wdata;
        end
    end

    assign mem_we    = xfer & cur_we;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences, random
// traffic, all cross-checked every cycle by a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int MAXB  = 8;
    localparam int WORDS = 1024;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          mem_we, busy;
    logic [1:0]    dbg_state;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(32'hC0DE0000 ^ (i * 32'h00010193));
    endfunction

    function automatic logic [AW-1:0] rand_addr(input int max_word);
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, max_word)) << 2;
        return a;
    endfunction

    // ---------------- memory environment ----------------
    logic [DW-1:0] mem [WORDS];
    logic          mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (reset_n && mem_we) begin
            mem[mem_addr[AW-1:2]] <= mem_wd;
        end
    end

    assign mem_rd = mem[mem_addr[AW-1:2]];

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] ref_mem [WORDS];
    bit            ref_ready = 1'b0;
    int            own = -1;
    int            cnt = 0;
    int            ptr = 0;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] hold0 = '0;
    logic [DW-1:0] hold1 = '0;

    always @(negedge clk) begin
        bit            r0, r1, rk, lk, ro, wk, eg0, eg1, ewe;
        logic [AW-1:0] ea, ak;
        logic [DW-1:0] ed, dk;
        int            k;
        if (!ref_ready) begin
            for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
            ref_ready = 1'b1;
        end
        if (!reset_n) begin
            own = -1; cnt = 0; ptr = 0;
            exp_q0.delete(); exp_q1.delete();
            hold0 = '0; hold1 = '0;
            check("rst_gnt",    64'({m0_gnt, m1_gnt}), 64'(0));
            check("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(0));
            check("rst_busy",   64'(busy), 64'(0));
            check("rst_mem_we", 64'(mem_we), 64'(0));
            check("rst_rdata0", 64'(m0_rdata), 64'(0));
            check("rst_rdata1", 64'(m1_rdata), 64'(0));
        end else begin
            r0  = m0_req;
            r1  = m1_req;
            eg0 = (own == 0) && r0;
            eg1 = (own == 1) && r1;
            check("gnt0", 64'(m0_gnt), 64'(eg0));
            check("gnt1", 64'(m1_gnt), 64'(eg1));
            check("busy", 64'(busy), 64'(own != -1));
            ea = '0; ed = '0; ewe = 1'b0;
            if (own == 0) begin ea = m0_addr; ed = m0_wdata; ewe = r0 && m0_we; end
            if (own == 1) begin ea = m1_addr; ed = m1_wdata; ewe = r1 && m1_we; end
            check("mem_addr", 64'(mem_addr), 64'(ea));
            check("mem_wd",   64'(mem_wd), 64'(ed));
            check("mem_we",   64'(mem_we), 64'(ewe));
            check("rvalid0", 64'(m0_rvalid), 64'(exp_q0.size() != 0));
            check("rvalid1", 64'(m1_rvalid), 64'(exp_q1.size() != 0));
            if (exp_q0.size() != 0) hold0 = exp_q0.pop_front();
            if (exp_q1.size() != 0) hold1 = exp_q1.pop_front();
            check("rdata0", 64'(m0_rdata), 64'(hold0));
            check("rdata1", 64'(m1_rdata), 64'(hold1));
            // what happens at the coming rising edge
            if (own == -1) begin
                if (r0 || r1) begin
                    own = (r0 && r1) ? ptr : (r1 ? 1 : 0);
                    cnt = 0;
                end
            end else begin
                k  = own;
                rk = (k == 1) ? r1 : r0;
                lk = (k == 1) ? m1_lock : m0_lock;
                ro = (k == 1) ? r0 : r1;
                wk = (k == 1) ? m1_we : m0_we;
                ak = (k == 1) ? m1_addr : m0_addr;
                dk = (k == 1) ? m1_wdata : m0_wdata;
                if (rk) begin
                    if (wk) ref_mem[ak[AW-1:2]] = dk;
                    else if (k == 1) exp_q1.push_back(ref_mem[ak[AW-1:2]]);
                    else exp_q0.push_back(ref_mem[ak[AW-1:2]]);
                    if (cnt < MAXB) cnt++;
                end
                if ((!rk && !lk) || (cnt == MAXB && ro)) begin
                    own = -1;
                    ptr = 1 - k;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int rst; int r0; int a0; int r1; int a1;
        int g0; int g1; int v0; int v1; int bz;
        int chk; logic [DW-1:0] rd;
    } vec_t;

    function automatic vec_t mk(input int rst, input int r0, input int a0, input int r1,
                                input int a1, input int g0, input int g1, input int v0,
                                input int v1, input int bz, input int chk,
                                input logic [DW-1:0] rd);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.bz = bz;
        v.chk = chk; v.rd = rd;
        return v;
    endfunction

    vec_t tbl [15];

    int n0, n1, nrv, first_rv, last_rv, first_g, kk;
    bit gap, early, lost, e0, e1;
    int ph;

    initial begin
        reset_n = 1'b0;
        idle_inputs();

        //            rst r0 a0     r1 a1     g0 g1 v0 v1 bz chk rd
        tbl[0]  = mk(1, 1, 'h200, 0, 'h000, 0, 0, 0, 0, 0, 0, '0);
        tbl[1]  = mk(0, 1, 'h200, 0, 'h000, 1, 0, 0, 0, 1, 0, '0);
        tbl[2]  = mk(0, 0, 'h000, 0, 'h000, 0, 0, 1, 0, 1, 1, init_word(128));
        tbl[3]  = mk(0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 0, '0);
        tbl[4]  = mk(1, 1, 'h100, 1, 'h300, 0, 0, 0, 0, 0, 0, '0);
        tbl[5]  = mk(0, 1, 'h100, 1, 'h300, 1, 0, 0, 0, 1, 0, '0);
        tbl[6]  = mk(0, 1, 'h104, 1, 'h300, 1, 0, 1, 0, 1, 1, init_word(64));
        tbl[7]  = mk(0, 0, 'h000, 1, 'h300, 0, 0, 1, 0, 1, 1, init_word(65));
        tbl[8]  = mk(0, 0, 'h000, 1, 'h300, 0, 0, 0, 0, 0, 0, '0);
        tbl[9]  = mk(0, 0, 'h000, 1, 'h300, 0, 1, 0, 0, 1, 0, '0);
        tbl[10] = mk(0, 0, 'h000, 0, 'h000, 0, 0, 0, 1, 1, 0, '0);
        tbl[11] = mk(0, 1, 'h108, 1, 'h304, 0, 0, 0, 0, 0, 0, '0);
        tbl[12] = mk(0, 1, 'h108, 1, 'h304, 1, 0, 0, 0, 1, 0, '0);
        tbl[13] = mk(0, 0, 'h000, 0, 'h000, 0, 0, 1, 0, 1, 1, init_word(66));
        tbl[14] = mk(0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 0, '0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst != 0) do_reset();
            m0_req = (tbl[i].r0 != 0); m0_we = 0; m0_addr = AW'(tbl[i].a0);
            m1_req = (tbl[i].r1 != 0); m1_we = 0; m1_addr = AW'(tbl[i].a1);
            m0_wdata = $urandom; m1_wdata = $urandom;
            @(negedge clk);
            check($sformatf("vec%0d_gnt0", i), 64'(m0_gnt), 64'(tbl[i].g0));
            check($sformatf("vec%0d_gnt1", i), 64'(m1_gnt), 64'(tbl[i].g1));
            check($sformatf("vec%0d_rvalid0", i), 64'(m0_rvalid), 64'(tbl[i].v0));
            check($sformatf("vec%0d_rvalid1", i), 64'(m1_rvalid), 64'(tbl[i].v1));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].bz));
            if (tbl[i].chk != 0)
                check($sformatf("vec%0d_rdata0", i), 64'(m0_rdata), 64'(tbl[i].rd));
            tick();
        end

        // both requesters saturate: 8 grants each with one IDLE cycle between
        do_reset();
        m0_req = 1; m1_req = 1;
        for (int c = 0; c < 45; c++) begin
            m0_addr = rand_addr(WORDS - 1);
            m1_addr = rand_addr(WORDS - 1);
            @(negedge clk);
            ph = (c >= 1) ? (c - 1) % 18 : 0;
            e0 = (c >= 1) && (ph < 8);
            e1 = (c >= 1) && (ph >= 9) && (ph <= 16);
            check($sformatf("burst_c%0d_gnt0", c), 64'(m0_gnt), 64'(e0));
            check($sformatf("burst_c%0d_gnt1", c), 64'(m1_gnt), 64'(e1));
            tick();
        end
        idle_inputs();
        tick();

        // m1 locked writes with request gaps while m0 waits
        do_reset();
        n0 = 0; n1 = 0; gap = 0; early = 0;
        for (int c = 0; c < 40; c++) begin
            m1_req = (n1 < 8) && !gap; m1_lock = (n1 < 8); m1_we = 1;
            m1_addr = AW'(32'h200 + n1 * 4); m1_wdata = $urandom;
            m0_req = (c >= 1); m0_we = 0; m0_addr = AW'(32'h200 + (n0 % 8) * 4);
            @(negedge clk);
            if (m0_gnt && n1 < 8) early = 1;
            if (m1_gnt) begin n1++; gap = 1; end else gap = 0;
            if (m0_gnt) n0++;
            tick();
        end
        check("lock_no_early_gnt0", 64'(early), 64'(0));
        check("lock_m1_transfers", 64'(n1), 64'(8));
        check("lock_m0_transfers", 64'(n0), 64'(23));
        idle_inputs();
        tick();

        // reset asserted in the middle of an m1 read burst
        do_reset();
        m1_req = 1; m1_we = 0; m1_addr = 12'h340;
        tick();
        tick();
        check("pre_rst_gnt1", 64'(m1_gnt), 64'(1));
        check("pre_rst_rvalid1", 64'(m1_rvalid), 64'(1));
        m1_we = 1; m1_wdata = 32'hDEADBEEF;
        #1;
        check("pre_rst_mem_we", 64'(mem_we), 64'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_gnt1", 64'(m1_gnt), 64'(0));
        check("mid_rst_rvalid1", 64'(m1_rvalid), 64'(0));
        check("mid_rst_mem_we", 64'(mem_we), 64'(0));
        check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) tick();
        reset_n = 1'b1;
        m1_we = 0; m0_req = 1; m0_we = 0; m0_addr = 12'h340; m1_addr = 12'h344;
        tick();
        check("post_rst_tie_gnt0", 64'(m0_gnt), 64'(1));
        check("post_rst_tie_gnt1", 64'(m1_gnt), 64'(0));
        idle_inputs();
        repeat (2) tick();

        // lone m0 burst of 20 reads
        do_reset();
        kk = 0; nrv = 0; first_rv = -1; last_rv = -1; first_g = -1; lost = 0;
        for (int c = 0; c < 30; c++) begin
            m0_req = (kk < 20); m0_we = 0; m0_addr = AW'(32'h400 + kk * 4);
            @(negedge clk);
            if (m0_gnt) begin
                if (first_g < 0) first_g = c;
                kk++;
            end
            if (m0_rvalid) begin
                nrv++;
                if (first_rv < 0) first_rv = c;
                last_rv = c;
            end
            if (c >= 1 && kk < 20 && !busy) lost = 1;
            tick();
        end
        check("lone_first_gnt", 64'(first_g), 64'(1));
        check("lone_transfers", 64'(kk), 64'(20));
        check("lone_rvalid_count", 64'(nrv), 64'(20));
        check("lone_first_rvalid", 64'(first_rv), 64'(2));
        check("lone_last_rvalid", 64'(last_rv), 64'(21));
        check("lone_ownership_held", 64'(lost), 64'(0));
        idle_inputs();
        tick();

        // random traffic over a small window so reads hit earlier writes
        do_reset();
        for (int c = 0; c < 600; c++) begin
            m0_req  = ($urandom_range(0, 3) != 0);
            m0_we   = ($urandom_range(0, 1) != 0);
            m0_lock = ($urandom_range(0, 7) == 0);
            m0_addr = rand_addr(63);
            m0_wdata = $urandom;
            m1_req  = ($urandom_range(0, 2) != 0);
            m1_we   = ($urandom_range(0, 1) != 0);
            m1_lock = ($urandom_range(0, 5) == 0);
            m1_addr = rand_addr(63);
            m1_wdata = $urandom;
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 12: memory byte-address width.
REQ-002 Parameter DW, default 32: data word width.
REQ-003 Parameter MAX_BURST, default 8: maximum consecutive transfers per ownership while the other requester waits.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 mN_req  in  1  requester N (N=0 core, N=1 loader/debug) wants a transfer this cycle.
REQ-007 mN_we  in  1  requester N: 1 write, 0 read.
REQ-008 mN_addr  in  AW  requester N word-aligned byte address.
REQ-009 mN_wdata  in  DW  requester N write data.
REQ-010 mN_lock  in  1  requester N keeps ownership across req gaps.
REQ-011 mN_gnt  out  1  transfer of requester N accepted this cycle.
REQ-012 mN_rvalid  out  1  read data for requester N valid; one-cycle pulse.
REQ-013 mN_rdata  out  DW  registered read data for requester N.
REQ-014 mem_addr / mem_wd / mem_we  out  AW/DW/1  to memory A/WD/WE.
REQ-015 mem_rd  in  DW  combinational read data from memory.
REQ-016 busy  out  1  high when state is not IDLE.

Function
REQ-017 FSM states IDLE, OWN0, OWN1; exactly one active.
REQ-018 IDLE: no grants; mem_we=0, mem_addr=0, mem_wd=0.
REQ-019 IDLE with any req: next state OWNk, k = sole requester, or the priority pointer if both request.
REQ-020 OWNk: mem_addr/mem_wd = mk_addr/mk_wdata; mem_we = mk_req & mk_we.
REQ-021 mk_gnt = (state==OWNk) & mk_req, combinational; the other gnt stays 0.
REQ-022 Transfer = cycle with req & gnt; the write commits at that cycle's rising edge.
REQ-023 Read transfer: mem_rd is captured into mk_rdata at the edge; mk_rvalid is high the following cycle only.
REQ-024 Latency: req rising in IDLE at cycle 0 gives gnt in cycle 1 and rvalid in cycle 2.
REQ-025 burst_cnt counts transfers in the current ownership; cleared on entering OWNk; saturates at MAX_BURST.
REQ-026 OWNk exits to IDLE when mk_req=0 & mk_lock=0.
REQ-027 OWNk exits to IDLE when burst_cnt reaches MAX_BURST and the other req=1, regardless of lock.
REQ-028 On any exit from OWNk the priority pointer becomes the other requester.
REQ-029 Lone requester exceeding MAX_BURST with the other idle keeps ownership; no forced exit.
REQ-030 Requester dropping req while lock=1 keeps ownership; grants resume when req returns.
REQ-031 A read transfer on the last OWNk cycle still produces its rvalid in the IDLE cycle that follows.
REQ-032 mN_rdata holds its value until the next read for N.

Reset
REQ-033 reset_n low: state=IDLE, burst_cnt=0, pointer=0 (core), all gnt/rvalid=0, rdata=0, busy=0, mem_we=0, regardless of clock.
REQ-034 Reset mid-burst discards the pending rvalid; no write occurs while reset_n is low.

Structure
REQ-035 Package mem_arb_pkg holds the state enumeration, the AW/DW defaults and the requester index constants.
REQ-036 One sub-module, rr_arb2, holds the two-way round-robin pointer and IDLE selection logic; all other logic is in mem_arbiter.

Verification
REQ-037 Only m0 reads 0x200: gnt0 in cycle 1 and rvalid0 in cycle 2 with rdata0 = memory word at 0x200; m1 signals all 0.
REQ-038 m0 and m1 both request from reset: OWN0 first; m1 gets gnt1 after m0 drops req plus one IDLE cycle; the next tie goes to m0.
REQ-039 Both continuously request with MAX_BURST=8: exactly 8 gnt0, then 1 IDLE cycle, then 8 gnt1, alternating.
REQ-040 m1 lock=1 writes 0x200..0x21C with one-cycle req gaps while m0 waits: m0 gets no grant until 8 transfers complete or lock drops.
REQ-041 reset_n pulled low mid-read in OWN1: gnt1/rvalid1 fall immediately, mem_we=0, state IDLE; the next tie goes to m0.
REQ-042 m0 lone burst of 20 reads: ownership is held throughout and 20 consecutive rvalid0 pulses follow.
